// File: rtl/potential_adder_0_if.sv
// Handshake and data bundle between the potential adder and its neighbours.
// Signal names match the original flat port list.
interface potential_adder_0_if;
  logic        ts_start;
  logic [31:0] decayed_potential;
  logic        w_valid;
  logic [31:0] w_data;
  logic        w_ready;
  logic        ts_end;
  logic [31:0] new_potential;
  logic        potential_valid;
  logic        spike;
  logic        refractory_active;
  logic        add_error;

  modport master (
    output ts_start, decayed_potential, w_valid, w_data, ts_end,
    input  w_ready, new_potential, potential_valid, spike, refractory_active, add_error
  );

  modport slave (
    input  ts_start, decayed_potential, w_valid, w_data, ts_end,
    output w_ready, new_potential, potential_valid, spike, refractory_active, add_error
  );
endinterface

// File: rtl/potential_adder_0.sv
// Per-neuron membrane accumulator: decayed potential + weighted inputs, threshold,
// spike/reset and refractory handling. Includes the combinational float adder.
module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);
  logic [31:0] w_b, w_big, w_sml;
  logic [7:0]  w_eb, w_es, w_d;
  logic [26:0] w_mb, w_ms0, w_msh, w_ms, w_norm;
  logic [27:0] w_sum;
  logic [9:0]  w_exp;
  logic [24:0] w_mr;
  logic        w_swap, w_rnd;

  always_comb begin
    w_b    = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
    w_swap = (w_b[30:0] > a_operand[30:0]);
    w_big  = w_swap ? w_b : a_operand;
    w_sml  = w_swap ? a_operand : w_b;
    w_eb   = (w_big[30:23] == '0) ? 8'd1 : w_big[30:23];
    w_es   = (w_sml[30:23] == '0) ? 8'd1 : w_sml[30:23];
    w_d    = w_eb - w_es;
    // 24-bit significand plus guard/round/sticky; shifted-out bits fold into sticky
    w_mb   = {|w_big[30:23], w_big[22:0], 3'b000};
    w_ms0  = {|w_sml[30:23], w_sml[22:0], 3'b000};
    w_msh  = w_ms0 >> w_d;
    w_ms   = {w_msh[26:1], w_msh[0] | (|(w_ms0 & ~({27{1'b1}} << w_d)))};
    if (w_big[31] == w_sml[31]) w_sum = {1'b0, w_mb} + {1'b0, w_ms};
    else                        w_sum = {1'b0, w_mb} - {1'b0, w_ms};
    w_exp = {2'b00, w_eb};
    if (w_sum[27]) begin
      w_norm = {w_sum[27:2], |w_sum[1:0]};
      w_exp  = w_exp + 10'd1;
    end else begin
      w_norm = w_sum[26:0];
    end
    for (int unsigned i = 0; i < 26; i++) begin
      if (!w_norm[26] && (w_exp > 10'd1)) begin
        w_norm = w_norm << 1;
        w_exp  = w_exp - 10'd1;
      end
    end
    w_rnd = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_mr  = {1'b0, w_norm[26:3]} + {24'd0, w_rnd};
    if (w_mr[24]) begin
      w_mr  = w_mr >> 1;
      w_exp = w_exp + 10'd1;
    end
    Exception = (a_operand[30:23] == 8'hFF) || (b_operand[30:23] == 8'hFF) || (w_exp >= 10'd255);
    if (w_sum == '0)             result = {w_big[31] & w_sml[31], 31'd0};
    else if (w_exp >= 10'd255)   result = {w_big[31], 8'hFF, 23'd0};
    else                         result = {w_big[31], (w_mr[23] ? w_exp[7:0] : 8'd0), w_mr[22:0]};
  end
endmodule

module potential_adder_0 #(
  parameter logic [31:0] THRESHOLD  = 32'h41F00000,
  parameter logic [31:0] V_RESET    = 32'h00000000,
  parameter int unsigned REFRACTORY = 2
) (
  input  logic                CLK,
  input  logic                RESETN,
  potential_adder_0_if.slave  bus
);
  localparam int unsigned CW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, CHECK, EMIT} state_t;

  state_t          r_state, w_next;
  logic [31:0]     r_acc, r_new_pot, w_sum;
  logic [CW-1:0]   r_refr_cnt, w_refr_next;
  logic            r_pvalid, r_spike, r_refr_active, r_add_error;
  logic            w_exc, w_fire, w_accept;

  function automatic logic f_ge(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:0] == '0) && (b[30:0] == '0)) return 1'b1;
    if (a[31] != b[31])                     return b[31];
    if (!a[31])                             return a[30:0] >= b[30:0];
    return a[30:0] <= b[30:0];
  endfunction

  Addition_Subtraction u_add (
    .a_operand  (r_acc),
    .b_operand  (bus.w_data),
    .AddBar_Sub (1'b0),
    .Exception  (w_exc),
    .result     (w_sum)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = (r_state == ACCUM) && bus.w_valid;
    w_fire      = (r_refr_cnt == '0) && f_ge(r_acc, THRESHOLD);
    w_refr_next = r_refr_cnt;
    case (r_state)
      IDLE:  if (bus.ts_start) w_next = ACCUM;
      ACCUM: if (bus.ts_end)   w_next = CHECK;
      CHECK: begin
        w_next = EMIT;
        if (w_fire)                  w_refr_next = CW'(REFRACTORY);
        else if (r_refr_cnt != '0)   w_refr_next = r_refr_cnt - CW'(1);
      end
      EMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Result registers load on the CHECK->EMIT edge so new_potential is already
  // valid in the same cycle that potential_valid/spike are high.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_acc         <= '0;
      r_new_pot     <= '0;
      r_refr_cnt    <= '0;
      r_pvalid      <= 1'b0;
      r_spike       <= 1'b0;
      r_refr_active <= 1'b0;
      r_add_error   <= 1'b0;
    end else begin
      r_pvalid      <= (r_state == CHECK);
      r_spike       <= (r_state == CHECK) && w_fire;
      r_refr_cnt    <= w_refr_next;
      r_refr_active <= (w_refr_next != '0);
      if ((r_state == IDLE) && bus.ts_start)
        r_acc <= (r_refr_cnt == '0) ? bus.decayed_potential : V_RESET;
      if (w_accept && (r_refr_cnt == '0)) begin
        if (w_exc) r_add_error <= 1'b1;
        else       r_acc       <= w_sum;
      end
      if (r_state == CHECK)
        r_new_pot <= w_fire ? V_RESET : r_acc;
    end
  end

  assign bus.w_ready           = (r_state == ACCUM);
  assign bus.new_potential     = r_new_pot;
  assign bus.potential_valid   = r_pvalid;
  assign bus.spike             = r_spike;
  assign bus.refractory_active = r_refr_active;
  assign bus.add_error         = r_add_error;
endmodule

// File: tb/tb_potential_adder_0.sv
// Bench for potential_adder_0: directed plan steps then random timesteps,
// checked against an integer-valued membrane model.
module tb_potential_adder_0;
  localparam int REFR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_refr = 0;
  int   wq[$];
  logic [31:0] wb[$];

  potential_adder_0_if bus ();

  potential_adder_0 #(
    .THRESHOLD  (32'h41F00000),
    .V_RESET    (32'h00000000),
    .REFRACTORY (REFR)
  ) dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i2f(input int v);
    int unsigned mag;
    int          k;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? unsigned'(-v) : unsigned'(v);
    k = 0;
    for (int i = 0; i < 24; i++) if (mag[i]) k = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + k);
    r[22:0]  = 23'(mag << (23 - k));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drives one timestep from the IDLE cycle up to the first cycle of EMIT.
  task automatic drive_ts(input logic [31:0] dpb, input bit together, input bit glitch, input bit gaps);
    bus.ts_start = 1'b1;  bus.decayed_potential = dpb;
    bus.w_valid  = 1'b1;  bus.w_data = i2f(1000);  bus.ts_end = glitch;
    chk("ready_idle", bus.w_ready, 0);
    tick();
    bus.ts_start = 1'b0;  bus.ts_end = 1'b0;  bus.w_valid = 1'b0;
    bus.decayed_potential = $urandom;
    foreach (wb[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.w_valid = 1'b0;
          chk("ready_gap", bus.w_ready, 1);
          tick();
        end
      end
      bus.w_valid  = 1'b1;  bus.w_data = wb[i];
      bus.ts_end   = together && (i == wb.size() - 1);
      bus.ts_start = glitch && (i == 0);
      bus.decayed_potential = i2f(77);
      chk("ready_accum", bus.w_ready, 1);
      tick();
      bus.ts_start = 1'b0;
    end
    if (!together || wb.size() == 0) begin
      bus.w_valid = 1'b0;  bus.ts_end = 1'b1;
      chk("ready_end", bus.w_ready, 1);
      tick();
    end
    bus.ts_end = 1'b0;  bus.w_valid = 1'b1;  bus.w_data = i2f(500);
    chk("ready_check", bus.w_ready, 0);
    chk("pvalid_check", bus.potential_valid, 0);
    tick();
    bus.w_valid = 1'b0;
  endtask

  task automatic check_emit(input logic [31:0] np, input bit sp, input bit ra, input bit ae);
    chk("pvalid_emit", bus.potential_valid, 1);
    chk("new_potential", bus.new_potential, np);
    chk("spike", bus.spike, sp);
    chk("refr_active", bus.refractory_active, ra);
    chk("add_error", bus.add_error, ae);
    chk("ready_emit", bus.w_ready, 0);
    tick();
    chk("pvalid_pulse", bus.potential_valid, 0);
    chk("spike_pulse", bus.spike, 0);
    chk("np_hold", bus.new_potential, np);
  endtask

  // Membrane model: integer potentials, threshold 30, REFR discarded timesteps after a spike.
  task automatic model_ts(input int dp, input bit together, input bit glitch, input bit gaps);
    int          s;
    bit          fire;
    logic [31:0] np;
    wb.delete();
    foreach (wq[i]) wb.push_back(i2f(wq[i]));
    if (m_refr == 0) begin
      s = dp;
      foreach (wq[i]) s += wq[i];
      fire = (s >= 30);
      np   = fire ? 32'h0 : i2f(s);
      if (fire) m_refr = REFR;
    end else begin
      fire = 1'b0;
      np   = 32'h0;
      m_refr--;
    end
    drive_ts(i2f(dp), together, glitch, gaps);
    check_emit(np, fire, m_refr != 0, 1'b0);
  endtask

  task automatic reset_mid(input int dp, input int w);
    bus.ts_start = 1'b1;  bus.decayed_potential = i2f(dp);
    tick();
    bus.ts_start = 1'b0;  bus.w_valid = 1'b1;  bus.w_data = i2f(w);
    tick();
    bus.w_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_np", bus.new_potential, 0);
    chk("rst_pvalid", bus.potential_valid, 0);
    chk("rst_spike", bus.spike, 0);
    chk("rst_refr", bus.refractory_active, 0);
    chk("rst_ready", bus.w_ready, 0);
    chk("rst_err", bus.add_error, 0);
    tick();
    rst_n = 1'b1;
    bus.ts_end = 1'b1;
    tick();
    bus.ts_end = 1'b0;
    repeat (3) begin
      chk("rst_no_pvalid", bus.potential_valid, 0);
      tick();
    end
    m_refr = 0;
  endtask

  initial begin
    bus.ts_start = 1'b0;  bus.decayed_potential = '0;
    bus.w_valid  = 1'b0;  bus.w_data = '0;  bus.ts_end = 1'b0;
    tick();
    tick();
    chk("reset_np", bus.new_potential, 0);
    chk("reset_pvalid", bus.potential_valid, 0);
    chk("reset_spike", bus.spike, 0);
    chk("reset_refr", bus.refractory_active, 0);
    chk("reset_ready", bus.w_ready, 0);
    chk("reset_err", bus.add_error, 0);
    rst_n = 1'b1;
    tick();

    wq = '{8, 3};     model_ts(10, 0, 0, 0);   // 21.0, no spike
    wq = '{10};       model_ts(21, 0, 0, 0);   // 31.0 fires
    wq = '{100};      model_ts(5, 0, 0, 0);    // refractory, discarded
    wq = '{100, 100}; model_ts(7, 0, 0, 0);    // refractory, last one
    wq = '{4};        model_ts(10, 0, 0, 0);   // normal again
    wq = '{10};       model_ts(20, 0, 0, 0);   // exactly 30.0 fires
    wq = {};          model_ts(0, 0, 0, 0);
    wq = {};          model_ts(0, 0, 0, 0);
    wq = '{2};        model_ts(-5, 0, 0, 0);   // -3.0
    wq = '{5, 6};     model_ts(12, 1, 1, 0);   // weight with ts_end, ignored ts_start
    wq = {};          model_ts(17, 0, 0, 0);   // empty timestep passes decayed through

    reset_mid(3, 4);
    wq = '{1};        model_ts(9, 0, 0, 0);
    wq = '{5, 5};     model_ts(25, 0, 0, 0);   // fires, refractory armed
    reset_mid(5, 50);
    wq = '{3};        model_ts(28, 0, 0, 0);   // would be discarded if refractory survived reset

    for (int t = 0; t < 25; t++) begin
      int nw;
      wq = {};
      nw = int'($urandom_range(0, 5));
      for (int k = 0; k < nw; k++) wq.push_back(int'($urandom_range(0, 20)) - 8);
      model_ts(int'($urandom_range(0, 45)) - 20, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end

    for (int k = 0; k < 4 && m_refr != 0; k++) begin
      wq = {};
      model_ts(0, 0, 0, 0);
    end
    wb = '{32'h7F000000};
    drive_ts(32'h7F000000, 1'b0, 1'b0, 1'b0);  // overflow: acc kept, error sticks, still fires
    check_emit(32'h0, 1'b1, REFR != 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
